div255_seq_ctrl: RTL

//  Sequencer for the Divby255 datapath: x[15:0], flg1..flg4, clk -> y[15:0].

---
 rtl/div255_seq_ctrl_pkg.sv | 40 ++++
 rtl/div255_phase_cnt.sv | 32 +++
 rtl/div255_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div255_seq_ctrl_pkg.sv
// Shared definitions for the Divby255 sequencer.
//   state_e   : 3-bit controller state encoding, IDLE..DONE
//   FLG_*     : datapath flag vectors, packed as {flg4, flg3, flg2, flg1}
//   cnt_width : phase-counter width for a given set of timing parameters
package div255_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StLoadHi = 3'd2,
    StLoadLo = 3'd3,
    StComp   = 3'd4,
    StRdMsb  = 3'd5,
    StRdLsb  = 3'd6,
    StDone   = 3'd7
  } state_e;

  // Flag vectors, bit order {flg4, flg3, flg2, flg1}. At most one bit is ever set.
  localparam logic [3:0] FLG_NONE  = 4'b0000;
  localparam logic [3:0] FLG_CLR   = 4'b0001;
  localparam logic [3:0] FLG_LOAD  = 4'b0010;
  localparam logic [3:0] FLG_RDMSB = 4'b0100;
  localparam logic [3:0] FLG_RDLSB = 4'b1000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One spare bit over clog2 so the largest reload value always fits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/div255_phase_cnt.sv
// Loadable down-counter shared by all timed controller states.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : reload value, i.e. (cycles in state - 1)
//   zero     : count has reached zero, i.e. this is the last cycle of the state
// The counter stops at zero rather than wrapping.
module div255_phase_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/div255_seq_ctrl.sv
// Sequencer for the Divby255 datapath.
// Accepts a 32-bit dividend, clears the datapath, loads the dividend as two 16-bit halves,
// waits for the computation, reads the quotient back as MSB then LSB half and returns it.
// One operation in flight; every output is registered.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid/in_ready    : dividend handshake, in_data is the 32-bit dividend
//   dp_x                 : datapath operand input
//   dp_flg1..dp_flg4     : clear / load / select-MSB / select-LSB strobes (mutually exclusive)
//   dp_y                 : datapath result half-word
//   out_valid/out_ready  : quotient handshake, out_data is {msb, lsb}
module div255_seq_ctrl
  import div255_seq_ctrl_pkg::*;
#(
  parameter int unsigned CLR_CYC  = 4,
  parameter int unsigned COMP_CYC = 8,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [15:0] dp_x,
  output logic        dp_flg1,
  output logic        dp_flg2,
  output logic        dp_flg3,
  output logic        dp_flg4,
  input  logic [15:0] dp_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int unsigned CntW = cnt_width(CLR_CYC, COMP_CYC, RD_LAT);

  // Reload values are (duration - 1): the state ends on the cycle the counter reads zero.
  localparam logic [CntW-1:0] ClrLd  = CntW'(CLR_CYC - 1);
  localparam logic [CntW-1:0] CompLd = CntW'(COMP_CYC - 1);
  localparam logic [CntW-1:0] RdLd   = CntW'(RD_LAT - 1);

  state_e      state_q;
  logic [3:0]  flg_q;
  logic [15:0] x_q;
  logic [31:0] dividend_q;
  logic [31:0] out_data_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic            step;
  logic [CntW-1:0] ld_val;
  logic            cnt_zero;

  // step: the current state is left on this clock edge. The counter is reloaded with the
  // duration of the state being entered, so every state starts with a fresh count.
  always_comb begin
    step   = 1'b0;
    ld_val = '0;
    unique case (state_q)
      StIdle: begin
        step   = in_valid & in_ready_q;
        ld_val = ClrLd;
      end
      StClear: begin
        step   = cnt_zero;
        ld_val = '0;
      end
      StLoadHi: begin
        step   = 1'b1;
        ld_val = '0;
      end
      StLoadLo: begin
        step   = 1'b1;
        ld_val = CompLd;
      end
      StComp: begin
        step   = cnt_zero;
        ld_val = RdLd;
      end
      StRdMsb: begin
        step   = cnt_zero;
        ld_val = RdLd;
      end
      StRdLsb: begin
        step   = cnt_zero;
        ld_val = '0;
      end
      StDone: begin
        step   = out_ready;
        ld_val = '0;
      end
      default: begin
        step   = 1'b0;
        ld_val = '0;
      end
    endcase
  end

  div255_phase_cnt #(
    .W(CntW)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (step),
    .load_val (ld_val),
    .zero     (cnt_zero)
  );

  // Outputs are computed for the state being entered, so they are valid from its first cycle.
  // Anything not assigned on a transition holds, which gives stable outputs under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flg_q       <= FLG_NONE;
      x_q         <= '0;
      dividend_q  <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (step) begin
      unique case (state_q)
        StIdle: begin
          dividend_q <= in_data;
          in_ready_q <= 1'b0;
          flg_q      <= FLG_CLR;
          x_q        <= '0;
          state_q    <= StClear;
        end
        StClear: begin
          flg_q   <= FLG_LOAD;
          x_q     <= dividend_q[31:16];
          state_q <= StLoadHi;
        end
        StLoadHi: begin
          // flg2 stays high; the second load strobe shifts in the low half.
          x_q     <= dividend_q[15:0];
          state_q <= StLoadLo;
        end
        StLoadLo: begin
          flg_q   <= FLG_NONE;
          state_q <= StComp;
        end
        StComp: begin
          flg_q   <= FLG_RDMSB;
          state_q <= StRdMsb;
        end
        StRdMsb: begin
          // dp_y has had RD_LAT cycles to settle on the MSB half.
          out_data_q[31:16] <= dp_y;
          flg_q             <= FLG_RDLSB;
          state_q           <= StRdLsb;
        end
        StRdLsb: begin
          out_data_q[15:0] <= dp_y;
          flg_q            <= FLG_NONE;
          out_valid_q      <= 1'b1;
          state_q          <= StDone;
        end
        StDone: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dp_x      = x_q;
  assign dp_flg1   = flg_q[0];
  assign dp_flg2   = flg_q[1];
  assign dp_flg3   = flg_q[2];
  assign dp_flg4   = flg_q[3];

endmodule
